// File: rtl/toggle_req_gen.sv
// toggle_req_gen: synchronises and debounces a raw push-button, emits one
// registered single-cycle toggle request per accepted press (drives t_ff.t)
// and exposes the debounced level.
// Optional feature: define TOGGLE_REQ_LONG_PRESS_EN to build the hold counter
// and the one-shot long_press pulse; otherwise long_press is tied low.
module toggle_req_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES     = 16,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic t,
  output logic pressed,
  output logic long_press
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Last count value of a debounce window; the shared counter never passes it.
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_btn_s;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_t_nxt;
  logic             r_t;
  logic             r_pressed;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_btn_s <= 1'b0;
    end else begin
      r_s1    <= btn;
      r_btn_s <= r_s1;
    end
  end

  // State, debounce counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_t       <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_t       <= w_t_nxt;
      r_pressed <= (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_WAIT);
    end
  end

  // Next-state logic: a level change is accepted only after the synchronised
  // input has held the new value for a full debounce window.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_t_nxt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_btn_s) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!r_btn_s) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = PRESSED;
          w_t_nxt     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!r_btn_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (r_btn_s) begin
          w_state_nxt = PRESSED;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign t       = r_t;
  assign pressed = r_pressed;

`ifdef TOGGLE_REQ_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [CNT_W-1:0] r_hold;
  logic             r_fired;
  logic             r_long;
  logic             w_enter_idle;

  assign w_enter_idle = (w_state_nxt == IDLE) && (r_state != IDLE);

  // Hold counter: counts held PRESSED cycles, frozen during release glitches,
  // saturates at its last value; the fired flag limits one pulse per press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold  <= '0;
      r_fired <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (w_t_nxt) begin
        r_hold <= '0;
      end else if ((r_state == PRESSED) && r_btn_s) begin
        if (r_hold == LONG_LAST) begin
          if (!r_fired) begin
            r_long  <= 1'b1;
            r_fired <= 1'b1;
          end
        end else begin
          r_hold <= r_hold + CNT_W'(1);
        end
      end
      if (w_enter_idle) begin
        r_fired <= 1'b0;
      end
    end
  end

  assign long_press = r_long;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_req_gen.sv
// Testbench for toggle_req_gen. The reference model treats the debouncer as
// "the accepted level flips once the synchronised button has disagreed with it
// for DEBOUNCE_CYCLES+1 consecutive samples", with t on every accepted rise
// and long_press on the LONG_CYCLES-th steadily-held cycle of a press.
module tb_toggle_req_gen;

  localparam int D     = 4;
  localparam int LONG  = 16;
  localparam int CNT_W = 8;
`ifdef TOGGLE_REQ_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic t, pressed, long_press;

  always #5 clk = ~clk;

  toggle_req_gen #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (LONG),
    .CNT_W          (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .t         (t),
    .pressed   (pressed),
    .long_press(long_press)
  );

  // Downstream toggle flip-flop driven by t.
  logic tq;
  always @(posedge clk) begin
    if (rst) tq <= 1'b0;
    else if (t) tq <= ~tq;
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state.
  bit m_s1, m_bs, m_lvl, m_t, m_long;
  int m_run, m_hold;

  // Observations gathered while stepping.
  int t_cnt, long_cnt, t_edge, long_edge;
  int t_edges[8];

  task automatic step(input logic b, input logic r);
    btn = b;
    rst = r;
    @(posedge clk);
    if (r) begin
      m_s1 = 0; m_bs = 0; m_lvl = 0; m_run = 0; m_hold = 0; m_t = 0; m_long = 0;
    end else begin
      m_t = 0;
      m_long = 0;
      if (m_bs != m_lvl) begin
        m_run++;
        if (m_run == D + 1) begin
          m_lvl = m_bs;
          m_run = 0;
          if (m_lvl) begin
            m_t = 1;
            m_hold = 0;
          end
        end
      end else begin
        if (m_lvl && m_run == 0) begin
          m_hold++;
          if (LP_EN && m_hold == LONG) m_long = 1;
        end
        m_run = 0;
      end
      m_bs = m_s1;
      m_s1 = b;
    end
    #1;
    cyc++;
    if (t === 1'b1) begin
      if (t_cnt < 8) t_edges[t_cnt] = cyc;
      t_cnt++;
      t_edge = cyc;
    end
    if (long_press === 1'b1) begin
      long_cnt++;
      long_edge = cyc;
    end
  endtask

  task automatic clear_obs();
    t_cnt = 0; long_cnt = 0; t_edge = -1; long_edge = -1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    checks++;
    if ({t, pressed, long_press, tq} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got t/pressed/long/q=%b%b%b%b want 0000", t, pressed, long_press, tq);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_clean_press();
    int k, j, fall;
    clear_obs();
    k = cyc + 1;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (t !== m_t || pressed !== m_lvl || long_press !== m_long) begin
        errors++;
        $display("FAIL clean_press_model cyc=%0d t=%b want %b pressed=%b want %b long=%b want %b",
                 cyc, t, m_t, pressed, m_lvl, long_press, m_long);
      end
    end
    checks++;
    if (t_cnt != 1 || t_edge != k + 2 + D) begin
      errors++;
      $display("FAIL clean_t_edge got count=%0d edge=%0d want count=1 edge=%0d", t_cnt, t_edge, k + 2 + D);
    end
    j = cyc + 1;
    fall = -1;
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0);
      if (pressed === 1'b0 && fall < 0) fall = cyc;
      checks++;
      if (t !== m_t || pressed !== m_lvl) begin
        errors++;
        $display("FAIL clean_release_model cyc=%0d t=%b want %b pressed=%b want %b", cyc, t, m_t, pressed, m_lvl);
      end
    end
    checks++;
    if (fall != j + D + 2) begin
      errors++;
      $display("FAIL clean_release_edge got=%0d want=%0d", fall, j + D + 2);
    end
  endtask

  task automatic test_bounce();
    logic pat[$] = '{1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int seen_p;
    clear_obs();
    seen_p = 0;
    foreach (pat[i]) begin
      step(pat[i], 1'b0);
      if (pressed === 1'b1) seen_p++;
      checks++;
      if (t !== m_t || pressed !== m_lvl) begin
        errors++;
        $display("FAIL bounce_model cyc=%0d t=%b want %b pressed=%b want %b", cyc, t, m_t, pressed, m_lvl);
      end
    end
    checks++;
    if (t_cnt != 0 || seen_p != 0) begin
      errors++;
      $display("FAIL bounce_reject got t_count=%0d pressed_cycles=%0d want 0 0", t_cnt, seen_p);
    end
  endtask

  task automatic test_release_glitch();
    int drops, t_before;
    clear_obs();
    drops = 0;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0);
      if (pressed !== 1'b1) drops++;
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      if (pressed !== 1'b1) drops++;
      checks++;
      if (t !== m_t || pressed !== m_lvl) begin
        errors++;
        $display("FAIL glitch_model cyc=%0d t=%b want %b pressed=%b want %b", cyc, t, m_t, pressed, m_lvl);
      end
    end
    checks++;
    if (drops != 0 || t_cnt != 1) begin
      errors++;
      $display("FAIL glitch_hold got drops=%0d t_count=%0d want 0 1", drops, t_cnt);
    end
    t_before = t_cnt;
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (t !== m_t || pressed !== m_lvl) begin
        errors++;
        $display("FAIL repress_model cyc=%0d t=%b want %b pressed=%b want %b", cyc, t, m_t, pressed, m_lvl);
      end
    end
    checks++;
    if (t_cnt != t_before + 1) begin
      errors++;
      $display("FAIL repress_second_t got t_count=%0d want %0d", t_cnt, t_before + 1);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_long_press();
    clear_obs();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (t !== m_t || pressed !== m_lvl || long_press !== m_long) begin
        errors++;
        $display("FAIL long_model cyc=%0d t=%b want %b long=%b want %b", cyc, t, m_t, long_press, m_long);
      end
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
    checks++;
    if (t_cnt != 1) begin
      errors++;
      $display("FAIL long_t_count got=%0d want=1", t_cnt);
    end
`ifdef TOGGLE_REQ_LONG_PRESS_EN
    checks++;
    if (long_cnt != 1 || long_edge - t_edge != LONG) begin
      errors++;
      $display("FAIL long_pulse got count=%0d delay=%0d want count=1 delay=%0d", long_cnt, long_edge - t_edge, LONG);
    end
`else
    checks++;
    if (long_cnt != 0) begin
      errors++;
      $display("FAIL long_disabled got count=%0d want 0", long_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_press();
    int k;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++;
    if ({t, pressed, long_press} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_outputs got t/pressed/long=%b%b%b want 000", t, pressed, long_press);
    end
    clear_obs();
    k = cyc + 1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (t !== m_t || pressed !== m_lvl) begin
        errors++;
        $display("FAIL midreset_model cyc=%0d t=%b want %b pressed=%b want %b", cyc, t, m_t, pressed, m_lvl);
      end
    end
    checks++;
    if (t_cnt != 1 || t_edge != k + 2 + D) begin
      errors++;
      $display("FAIL midreset_t_edge got count=%0d edge=%0d want count=1 edge=%0d", t_cnt, t_edge, k + 2 + D);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    bit exp_q, prev_t;
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    clear_obs();
    exp_q = 0;
    prev_t = 0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 2 * (D + 1); i++) begin
        step((p < 3) && (i < D + 1), 1'b0);
        if (prev_t) exp_q = ~exp_q;
        prev_t = m_t;
        checks++;
        if (t !== m_t || pressed !== m_lvl || tq !== exp_q) begin
          errors++;
          $display("FAIL b2b_model cyc=%0d t=%b want %b pressed=%b want %b q=%b want %b",
                   cyc, t, m_t, pressed, m_lvl, tq, exp_q);
        end
      end
    end
    checks++;
    if (t_cnt != 3 || tq !== 1'b1) begin
      errors++;
      $display("FAIL b2b_toggles got t_count=%0d q=%b want 3 1", t_cnt, tq);
    end
    checks++;
    if (t_cnt >= 3 && (t_edges[1] - t_edges[0] != 2 * D + 2 || t_edges[2] - t_edges[1] != 2 * D + 2)) begin
      errors++;
      $display("FAIL b2b_spacing got %0d,%0d want %0d", t_edges[1] - t_edges[0], t_edges[2] - t_edges[1], 2 * D + 2);
    end
  endtask

  task automatic test_random();
    logic lvl;
    int run;
    lvl = 0;
    run = 0;
    for (int i = 0; i < 600; i++) begin
      if (run == 0) begin
        lvl = ~lvl;
        run = $urandom_range(1, 3 * D);
      end
      run--;
      step(lvl, ($urandom_range(0, 99) == 0));
      checks++;
      if (t !== m_t || pressed !== m_lvl || long_press !== m_long) begin
        errors++;
        $display("FAIL random_model cyc=%0d t=%b want %b pressed=%b want %b long=%b want %b",
                 cyc, t, m_t, pressed, m_lvl, long_press, m_long);
      end
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (t !== m_t || pressed !== m_lvl || long_press !== m_long) begin
        errors++;
        $display("FAIL random_tail_model cyc=%0d t=%b want %b long=%b want %b", cyc, t, m_t, long_press, m_long);
      end
    end
  endtask

  initial begin
    clear_obs();
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_long_press();
    test_reset_mid_press();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
